// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit path.
//   UART_DATA_W            : serial word width (bits)
//   UART_TX_FIFO_DEPTH     : default depth of the TX byte buffer (power of two, >= 4)
//   UART_TX_FIFO_AFULL_THR : default almost-full threshold for the TX buffer
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DATA_W            = 8;
    localparam int unsigned UART_TX_FIFO_DEPTH     = 16;
    localparam int unsigned UART_TX_FIFO_AFULL_THR = 12;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_if
// Write/read handshake bundle of the UART TX byte buffer.
//   slave  modport : FIFO side (takes wr_*/rd_en, drives flags, pulses and head word)
//   master modport : user side (host writer plus TX serializer reader)
// Signals:
//   wr_en_i, wr_data_i          push request and data
//   full_o, almost_full_o       write-side flags
//   overflow_o                  1-cycle pulse, push attempted while full
//   rd_en_i                     pop request, one pulse per consumed word
//   rd_data_o, empty_o          head word (valid while empty_o = 0)
//   underflow_o                 1-cycle pulse, pop attempted while empty
//   level_o                     occupancy, only when UART_TX_FIFO_LEVEL_EN is defined
// ----------------------------------------------------------------------------
interface uart_tx_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = UART_TX_FIFO_DEPTH
) ();

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              wr_en_i;
    logic [DATA_W-1:0] wr_data_i;
    logic              full_o;
    logic              almost_full_o;
    logic              overflow_o;
    logic              rd_en_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              empty_o;
    logic              underflow_o;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [LVL_W-1:0]  level_o;
`endif

    modport slave (
`ifdef UART_TX_FIFO_LEVEL_EN
        output level_o,
`endif
        input  wr_en_i,
        input  wr_data_i,
        input  rd_en_i,
        output full_o,
        output almost_full_o,
        output overflow_o,
        output rd_data_o,
        output empty_o,
        output underflow_o
    );

    modport master (
`ifdef UART_TX_FIFO_LEVEL_EN
        input  level_o,
`endif
        output wr_en_i,
        output wr_data_i,
        output rd_en_i,
        input  full_o,
        input  almost_full_o,
        input  overflow_o,
        input  rd_data_o,
        input  empty_o,
        input  underflow_o
    );

endinterface

// File: rtl/uart_fifo_mem.sv
// ----------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x DATA_W storage for the TX FIFO: synchronous write, asynchronous read,
// no reset so it maps onto distributed RAM.
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe (already qualified by the FIFO control)
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_addr_i  read address
//   rd_data_o  read data (combinational)
// ----------------------------------------------------------------------------
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DEPTH  = UART_TX_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[rd_addr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// First-word-fall-through byte buffer between the host write side and the UART
// TX serializer. The head word sits on rd_data_o whenever empty_o = 0; the
// serializer samples it and pulses rd_en_i to pop.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous reset, active-high (pointers and pulses only)
//   bus_io  uart_tx_fifo_if.slave: wr_en/wr_data/full/almost_full/overflow,
//           rd_en/rd_data/empty/underflow, and level_o when enabled
// Configuration:
//   UART_TX_FIFO_LEVEL_EN  when defined, drives bus_io.level_o = occupancy
// DEPTH must be a power of two >= 4; AFULL_THR must lie in 1..DEPTH.
// ----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W    = UART_DATA_W,
    parameter int unsigned DEPTH     = UART_TX_FIFO_DEPTH,
    parameter int unsigned AFULL_THR = UART_TX_FIFO_AFULL_THR
) (
    input logic           clk_i,
    input logic           rst_i,
    uart_tx_fifo_if.slave bus_io
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    // Extra MSB separates full from empty when the address bits match.
    localparam int unsigned PTR_W  = ADDR_W + 1;

    localparam logic [PTR_W-1:0] FULL_CNT  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_CNT = PTR_W'(AFULL_THR);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              r_overflow;
    logic              r_underflow;

    logic [PTR_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rd_data;

    // Modulo-2*DEPTH difference is the occupancy, 0..DEPTH.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == FULL_CNT);

    // Decisions use pre-edge flags, so a pop never frees room for a same-cycle
    // push when full, and a push never feeds a same-cycle pop when empty.
    assign w_push = bus_io.wr_en_i && !w_full;
    assign w_pop  = bus_io.rd_en_i && !w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_overflow  <= bus_io.wr_en_i && w_full;
            r_underflow <= bus_io.rd_en_i && w_empty;
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (w_push && !rst_i),
        .wr_addr_i (r_wr_ptr[ADDR_W-1:0]),
        .wr_data_i (bus_io.wr_data_i),
        .rd_addr_i (r_rd_ptr[ADDR_W-1:0]),
        .rd_data_o (w_rd_data)
    );

    assign bus_io.rd_data_o     = w_rd_data;
    assign bus_io.empty_o       = w_empty;
    assign bus_io.full_o        = w_full;
    assign bus_io.almost_full_o = (w_count >= AFULL_CNT);
    assign bus_io.overflow_o    = r_overflow;
    assign bus_io.underflow_o   = r_underflow;
`ifdef UART_TX_FIFO_LEVEL_EN
    assign bus_io.level_o       = w_count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Self-checking bench for uart_tx_fifo: a short table of single-cycle vectors
// with hand-computed flag values, then multi-cycle sequences checked against a
// queue model of the FIFO contents.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned AFULL_THR = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_THR (AFULL_THR)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [DATA_W-1:0] sb_q [$];

    typedef struct {
        logic              rst;
        logic              wr;
        logic [DATA_W-1:0] wd;
        logic              rd;
        logic              e_empty;
        logic              e_full;
        logic              e_afull;
        logic              e_ovf;
        logic              e_unf;
        int unsigned       e_lvl;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the queue model after an edge.
    task automatic check_state(input logic exp_ovf, input logic exp_unf);
        int unsigned n;
        n = sb_q.size();
        chk("empty", 32'(bus.empty_o), 32'(n == 0));
        chk("full", 32'(bus.full_o), 32'(n == DEPTH));
        chk("almost_full", 32'(bus.almost_full_o), 32'(n >= AFULL_THR));
        chk("overflow", 32'(bus.overflow_o), 32'(exp_ovf));
        chk("underflow", 32'(bus.underflow_o), 32'(exp_unf));
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("level", 32'(bus.level_o), n);
`endif
        if (n != 0) begin
            chk("head", 32'(bus.rd_data_o), 32'(sb_q[0]));
        end
    endtask

    // One clock cycle: drive inputs, update the model with pre-edge flags,
    // compare popped data before the edge and all outputs after it.
    task automatic step(input logic r, input logic w, input logic [DATA_W-1:0] d,
                        input logic p);
        bit                was_full;
        bit                was_empty;
        logic              exp_ovf;
        logic              exp_unf;
        logic [DATA_W-1:0] exp_d;
        rst            = r;
        bus.wr_en_i    = w;
        bus.wr_data_i  = d;
        bus.rd_en_i    = p;
        was_full  = (sb_q.size() == DEPTH);
        was_empty = (sb_q.size() == 0);
        exp_ovf   = !r && w && was_full;
        exp_unf   = !r && p && was_empty;
        if (r) begin
            sb_q.delete();
        end else begin
            if (p && !was_empty) begin
                exp_d = sb_q.pop_front();
                chk("pop_data", 32'(bus.rd_data_o), 32'(exp_d));
            end
            if (w && !was_full) begin
                sb_q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        check_state(exp_ovf, exp_unf);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        bus.wr_en_i   = 1'b0;
        bus.wr_data_i = '0;
        bus.rd_en_i   = 1'b0;

        //            rst wr  wd     rd   empty full afull ovf unf lvl
        vecs[0]  = '{1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0}; // reset wins
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        // Reset, single push/pop, underflow and empty-boundary vectors.
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd);
            chk("tbl_empty", 32'(bus.empty_o), 32'(vecs[i].e_empty));
            chk("tbl_full", 32'(bus.full_o), 32'(vecs[i].e_full));
            chk("tbl_afull", 32'(bus.almost_full_o), 32'(vecs[i].e_afull));
            chk("tbl_ovf", 32'(bus.overflow_o), 32'(vecs[i].e_ovf));
            chk("tbl_unf", 32'(bus.underflow_o), 32'(vecs[i].e_unf));
`ifdef UART_TX_FIFO_LEVEL_EN
            chk("tbl_level", 32'(bus.level_o), vecs[i].e_lvl);
`endif
        end

        // Fill to full: almost_full from the 12th word, full after the 16th.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(i), 1'b0);
            chk("fill_afull", 32'(bus.almost_full_o), 32'(i >= 11));
            chk("fill_full", 32'(bus.full_o), 32'(i == 15));
        end
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        chk("ovf_pulse", 32'(bus.overflow_o), 32'd1);
        idle();
        chk("ovf_clear", 32'(bus.overflow_o), 32'd0);
        chk("ovf_head", 32'(bus.rd_data_o), 32'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
        end
        chk("drained", 32'(bus.empty_o), 32'd1);

        // Full with simultaneous wr+rd: pop wins, push dropped.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        end
        step(1'b0, 1'b1, 8'hEE, 1'b1);
        chk("full_wr_rd_ovf", 32'(bus.overflow_o), 32'd1);
        chk("full_wr_rd_full", 32'(bus.full_o), 32'd0);
        chk("full_wr_rd_head", 32'(bus.rd_data_o), 32'h41);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("full_wr_rd_level", 32'(bus.level_o), 32'd15);
`endif
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
        end
        // Empty with simultaneous wr+rd: push wins, pop ignored.
        step(1'b0, 1'b1, 8'h77, 1'b1);
        chk("empty_wr_rd_unf", 32'(bus.underflow_o), 32'd1);
        chk("empty_wr_rd_empty", 32'(bus.empty_o), 32'd0);
        chk("empty_wr_rd_head", 32'(bus.rd_data_o), 32'h77);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("empty_wr_rd_level", 32'(bus.level_o), 32'd1);
`endif
        step(1'b0, 1'b0, '0, 1'b1);

        // Streaming: 40 words through a partly filled FIFO, wrapping the pointers.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
        end
        while (sb_q.size() != 0) begin
            step(1'b0, 1'b0, '0, 1'b1);
        end

        // Reset mid-stream with 7 words stored.
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
        end
        step(1'b1, 1'b0, '0, 1'b0);
        chk("rst_empty", 32'(bus.empty_o), 32'd1);
        chk("rst_afull", 32'(bus.almost_full_o), 32'd0);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk("rst_level", 32'(bus.level_o), 32'd0);
`endif
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        chk("post_rst_head", 32'(bus.rd_data_o), 32'h5A);
        step(1'b0, 1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
